// File: rtl/vfm_trace_pkg.sv
// rtl/vfm_trace_pkg.sv - shared types, opcode constants and mnemonic lookup for MC1 trace blocks
package vfm_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_DRAIN   = 2'd3
   } trace_state_t;

   // Wide all-ones pattern; users slice it to their own IW width.
   localparam logic [63:0] STALL_IW = '1;

   localparam logic [5:0] OPC_LD   = 6'h00;
   localparam logic [5:0] OPC_ST   = 6'h01;
   localparam logic [5:0] OPC_CPY  = 6'h02;
   localparam logic [5:0] OPC_SWAP = 6'h03;
   localparam logic [5:0] OPC_JUMP = 6'h04;
   localparam logic [5:0] OPC_ADD  = 6'h05;
   localparam logic [5:0] OPC_SUB  = 6'h06;
   localparam logic [5:0] OPC_ADDC = 6'h07;
   localparam logic [5:0] OPC_SUBC = 6'h08;
   localparam logic [5:0] OPC_NOT  = 6'h09;
   localparam logic [5:0] OPC_AND  = 6'h0A;
   localparam logic [5:0] OPC_OR   = 6'h0B;
   localparam logic [5:0] OPC_SRA  = 6'h0C;
   localparam logic [5:0] OPC_RRC  = 6'h0D;
   localparam logic [5:0] OPC_VADD = 6'h0E;
   localparam logic [5:0] OPC_VSUB = 6'h0F;
   localparam logic [5:0] OPC_MUL  = 6'h10;
   localparam logic [5:0] OPC_DIV  = 6'h11;
   localparam logic [5:0] OPC_XOR  = 6'h12;
   localparam logic [5:0] OPC_SHRL = 6'h13;
   localparam logic [5:0] OPC_SHRA = 6'h14;
   localparam logic [5:0] OPC_ROTL = 6'h15;
   localparam logic [5:0] OPC_ROTR = 6'h16;
   localparam logic [5:0] OPC_RLN  = 6'h17;
   localparam logic [5:0] OPC_RLZ  = 6'h18;
   localparam logic [5:0] OPC_RRN  = 6'h19;
   localparam logic [5:0] OPC_RRZ  = 6'h1A;
   localparam logic [5:0] OPC_CALL = 6'h1B;
   localparam logic [5:0] OPC_RET  = 6'h1C;
   localparam logic [5:0] OPC_IN   = 6'h1D;
   localparam logic [5:0] OPC_OUT  = 6'h1E;
   localparam logic [5:0] OPC_VADC = 6'h20;
   localparam logic [5:0] OPC_VSBC = 6'h21;
   localparam logic [5:0] OPC_CMP  = 6'h30;
   localparam logic [5:0] OPC_NOP  = 6'h38;

   function automatic logic [31:0] mnemonic4(input logic [5:0] opc);
      logic [31:0] r_txt;
      case (opc)
         OPC_LD:   r_txt = "LD  ";
         OPC_ST:   r_txt = "ST  ";
         OPC_CPY:  r_txt = "CPY ";
         OPC_SWAP: r_txt = "SWAP";
         OPC_JUMP: r_txt = "JUMP";
         OPC_ADD:  r_txt = "ADD ";
         OPC_SUB:  r_txt = "SUB ";
         OPC_ADDC: r_txt = "ADDC";
         OPC_SUBC: r_txt = "SUBC";
         OPC_NOT:  r_txt = "NOT ";
         OPC_AND:  r_txt = "AND ";
         OPC_OR:   r_txt = "OR  ";
         OPC_SRA:  r_txt = "SRA ";
         OPC_RRC:  r_txt = "RRC ";
         OPC_VADD: r_txt = "VADD";
         OPC_VSUB: r_txt = "VSUB";
         OPC_MUL:  r_txt = "MUL ";
         OPC_DIV:  r_txt = "DIV ";
         OPC_XOR:  r_txt = "XOR ";
         OPC_SHRL: r_txt = "SHRL";
         OPC_SHRA: r_txt = "SHRA";
         OPC_ROTL: r_txt = "ROTL";
         OPC_ROTR: r_txt = "ROTR";
         OPC_RLN:  r_txt = "RLN ";
         OPC_RLZ:  r_txt = "RLZ ";
         OPC_RRN:  r_txt = "RRN ";
         OPC_RRZ:  r_txt = "RRZ ";
         OPC_CALL: r_txt = "CALL";
         OPC_RET:  r_txt = "RET ";
         OPC_IN:   r_txt = "IN  ";
         OPC_OUT:  r_txt = "OUT ";
         OPC_VADC: r_txt = "VADC";
         OPC_VSBC: r_txt = "VSBC";
         OPC_CMP:  r_txt = "CMP ";
         OPC_NOP:  r_txt = "NOP ";
         default:  r_txt = "NDEF";
      endcase
      return r_txt;
   endfunction

endpackage

// File: rtl/vfm_iw_mnemonic.sv
// rtl/vfm_iw_mnemonic.sv - combinational IW to 4-char ASCII mnemonic
// A STALL word takes precedence over its (meaningless) opcode field.
module vfm_iw_mnemonic
   import vfm_trace_pkg::*;
#(
   parameter int IW_W = 14
)(
   input  logic [IW_W-1:0] i_iw,
   output logic [31:0]     o_ascii
);

   logic w_is_stall;

   assign w_is_stall = (i_iw == STALL_IW[IW_W-1:0]);
   assign o_ascii    = w_is_stall ? "STAL" : mnemonic4(i_iw[IW_W-1:IW_W-6]);

endmodule

// File: rtl/vfm_iw_trace_buffer.sv
// rtl/vfm_iw_trace_buffer.sv - circular IW trace capture with opcode trigger and oldest-first drain
// Capture runs until trigger plus post window, then the frozen buffer streams out over valid/ready.
module vfm_iw_trace_buffer
   import vfm_trace_pkg::*;
#(
   parameter int IW_W       = 14,
   parameter int DEPTH      = 16,
   parameter int TS_W       = 16,
   parameter int POST_TRIG  = 4,
   parameter bit FILTER_STL = 1'b1
)(
   input  logic                   Clk_pin,
   input  logic                   Reset_pin,
   input  logic [IW_W-1:0]        IW_in,
   input  logic                   IW_valid,
   input  logic                   Arm,
   input  logic                   Trig_en,
   input  logic [5:0]             Trig_opc,
   input  logic                   Rd_ready,
   output logic                   Rd_valid,
   output logic [IW_W-1:0]        Rd_IW,
   output logic [TS_W-1:0]        Rd_TS,
   output logic [31:0]            Rd_ASCII,
   output logic                   Rd_last,
   output logic [1:0]             Trace_state,
   output logic [$clog2(DEPTH):0] Count,
   output logic                   Overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = IW_W + TS_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);

   trace_state_t     r_state, w_state_nxt;
   logic [TS_W-1:0]  r_ts;
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_count, r_post_cnt;
   logic             r_overflow;
   logic [ENT_W-1:0] r_mem [DEPTH];
   logic             r_rd_valid, r_rd_last;
   logic [IW_W-1:0]  r_rd_iw;
   logic [TS_W-1:0]  r_rd_ts;
   logic [31:0]      r_rd_ascii;

   logic             w_capturing, w_filtered, w_arm, w_rec, w_trig, w_full;
   logic             w_xfer, w_load_first, w_load;
   logic [PTR_W-1:0] w_oldest, w_rd_addr;
   logic [ENT_W-1:0] w_rd_ent;
   logic [IW_W-1:0]  w_rd_ent_iw;
   logic [TS_W-1:0]  w_rd_ent_ts;
   logic [31:0]      w_rd_ent_ascii;

   assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
   assign w_filtered  = FILTER_STL && (IW_in == STALL_IW[IW_W-1:0]);
   assign w_arm       = Arm && (r_state != ST_DRAIN);
   // Arm beats any IW issued in the same cycle.
   assign w_rec       = w_capturing && IW_valid && !w_filtered && !Arm;
   assign w_trig      = w_rec && (r_state == ST_CAPTURE) && Trig_en &&
                        (IW_in[IW_W-1:IW_W-6] == Trig_opc);
   assign w_full      = (r_count == DEPTH_C);

   assign w_xfer       = r_rd_valid && Rd_ready;
   assign w_load_first = (r_state == ST_DRAIN) && !r_rd_valid;
   assign w_load       = w_load_first || (w_xfer && !r_rd_last);
   // With Count==DEPTH the low bits are zero, so oldest equals wr_ptr.
   assign w_oldest     = r_wr_ptr - r_count[PTR_W-1:0];
   assign w_rd_addr    = w_load_first ? w_oldest : r_rd_ptr;
   assign w_rd_ent     = r_mem[w_rd_addr];
   assign w_rd_ent_iw  = w_rd_ent[ENT_W-1:TS_W];
   assign w_rd_ent_ts  = w_rd_ent[TS_W-1:0];

   vfm_iw_mnemonic #(.IW_W(IW_W)) u_mnemonic (
      .i_iw    (w_rd_ent_iw),
      .o_ascii (w_rd_ent_ascii)
   );

   always_ff @(posedge Clk_pin or posedge Reset_pin) begin
      if (Reset_pin) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (Arm) w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (Arm)         w_state_nxt = ST_CAPTURE;
            else if (w_trig) w_state_nxt = (POST_TRIG == 0) ? ST_DRAIN : ST_POST;
         end
         ST_POST: begin
            if (Arm)                                       w_state_nxt = ST_CAPTURE;
            else if (w_rec && (r_post_cnt == CNT_W'(1)))   w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_xfer && r_rd_last) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk_pin or posedge Reset_pin) begin
      if (Reset_pin) begin
         r_ts       <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_post_cnt <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (w_arm) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
         end else if (w_rec) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_full) r_overflow <= 1'b1;
            else        r_count    <= r_count + 1'b1;
         end else if (w_xfer) begin
            r_count <= r_count - 1'b1;
         end
         if (w_trig)                            r_post_cnt <= POST_C;
         else if (w_rec && r_state == ST_POST)  r_post_cnt <= r_post_cnt - 1'b1;
      end
   end

   always_ff @(posedge Clk_pin) begin
      if (w_rec) r_mem[r_wr_ptr] <= {IW_in, r_ts};
   end

   // Read stage: Count still holds the entries not yet transferred, so last = one remaining.
   always_ff @(posedge Clk_pin or posedge Reset_pin) begin
      if (Reset_pin) begin
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_rd_ptr   <= '0;
         r_rd_iw    <= '0;
         r_rd_ts    <= '0;
         r_rd_ascii <= '0;
      end else if (w_load) begin
         r_rd_valid <= 1'b1;
         r_rd_last  <= w_load_first ? (r_count == CNT_W'(1)) : (r_count == CNT_W'(2));
         r_rd_ptr   <= w_rd_addr + 1'b1;
         r_rd_iw    <= w_rd_ent_iw;
         r_rd_ts    <= w_rd_ent_ts;
         r_rd_ascii <= w_rd_ent_ascii;
      end else if (w_xfer) begin
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
      end
   end

   assign Rd_valid    = r_rd_valid;
   assign Rd_IW       = r_rd_iw;
   assign Rd_TS       = r_rd_ts;
   assign Rd_ASCII    = r_rd_ascii;
   assign Rd_last     = r_rd_last;
   assign Trace_state = r_state;
   assign Count       = r_count;
   assign Overflow    = r_overflow;

endmodule

// File: tb/tb_vfm_iw_trace_buffer.sv
// tb/tb_vfm_iw_trace_buffer.sv - directed bench: instance A (POST_TRIG=4, filter on), B (POST_TRIG=0, filter off)
module tb_vfm_iw_trace_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [13:0] iw;
   logic        iw_valid, arm, trig_en, rd_ready;
   logic [5:0]  trig_opc;

   logic        a_valid, a_last, a_ovf, b_valid, b_last, b_ovf;
   logic [13:0] a_iw, b_iw;
   logic [15:0] a_ts, b_ts;
   logic [31:0] a_ascii, b_ascii;
   logic [1:0]  a_state, b_state;
   logic [4:0]  a_count, b_count;

   logic        o_valid, o_last, o_ovf;
   logic [13:0] o_iw;
   logic [15:0] o_ts;
   logic [31:0] o_ascii;
   logic [1:0]  o_state;
   logic [4:0]  o_count;

   logic [15:0] cyc;
   logic [15:0] ts1 [5];
   logic [15:0] ts2 [21];
   logic [15:0] ts3 [2];

   int n_assert = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 16'd0;
      else     cyc <= cyc + 16'd1;
   end

   vfm_iw_trace_buffer #(.POST_TRIG(4), .FILTER_STL(1'b1)) u_a (
      .Clk_pin(clk), .Reset_pin(rst), .IW_in(iw), .IW_valid(iw_valid & ~sel),
      .Arm(arm & ~sel), .Trig_en(trig_en), .Trig_opc(trig_opc), .Rd_ready(rd_ready & ~sel),
      .Rd_valid(a_valid), .Rd_IW(a_iw), .Rd_TS(a_ts), .Rd_ASCII(a_ascii), .Rd_last(a_last),
      .Trace_state(a_state), .Count(a_count), .Overflow(a_ovf)
   );

   vfm_iw_trace_buffer #(.POST_TRIG(0), .FILTER_STL(1'b0)) u_b (
      .Clk_pin(clk), .Reset_pin(rst), .IW_in(iw), .IW_valid(iw_valid & sel),
      .Arm(arm & sel), .Trig_en(trig_en), .Trig_opc(trig_opc), .Rd_ready(rd_ready & sel),
      .Rd_valid(b_valid), .Rd_IW(b_iw), .Rd_TS(b_ts), .Rd_ASCII(b_ascii), .Rd_last(b_last),
      .Trace_state(b_state), .Count(b_count), .Overflow(b_ovf)
   );

   assign o_valid = sel ? b_valid : a_valid;
   assign o_last  = sel ? b_last  : a_last;
   assign o_ovf   = sel ? b_ovf   : a_ovf;
   assign o_iw    = sel ? b_iw    : a_iw;
   assign o_ts    = sel ? b_ts    : a_ts;
   assign o_ascii = sel ? b_ascii : a_ascii;
   assign o_state = sel ? b_state : a_state;
   assign o_count = sel ? b_count : a_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (o_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("rd_valid_wait", 32'(o_valid), 32'd1);
   endtask

   initial begin
      sel = 1'b0; iw = '0; iw_valid = 1'b0; arm = 1'b0; trig_en = 1'b0;
      trig_opc = '0; rd_ready = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_state",  32'(o_state), 32'd0);
         chk("rst_count",  32'(o_count), 32'd0);
         chk("rst_ovf",    32'(o_ovf),   32'd0);
         chk("rst_valid",  32'(o_valid), 32'd0);
         chk("rst_last",   32'(o_last),  32'd0);
         chk("rst_iw",     32'(o_iw),    32'd0);
         chk("rst_ts",     32'(o_ts),    32'd0);
         chk("rst_ascii",  o_ascii,      32'd0);
      end

      // A: trigger on first ADD, four post-trigger entries
      sel = 1'b0; #1;
      trig_en = 1'b1; trig_opc = 6'h05; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      chk("t1_armed_state", 32'(o_state), 32'd1);
      chk("t1_armed_count", 32'(o_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         iw = 14'(14'h0512 + i); iw_valid = 1'b1; ts1[i] = cyc;
         @(negedge clk);
         chk("t1_state", 32'(o_state), (i == 4) ? 32'd3 : 32'd2);
      end
      iw_valid = 1'b0;
      chk("t1_count",       32'(o_count), 32'd5);
      chk("t1_ovf",         32'(o_ovf),   32'd0);
      chk("t1_valid_entry", 32'(o_valid), 32'd0);
      @(negedge clk);
      chk("t1_valid_rise",  32'(o_valid), 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("t1_hold_iw",    32'(o_iw),   32'h0512);
         chk("t1_hold_ts",    32'(o_ts),   32'(ts1[0]));
         chk("t1_hold_ascii", o_ascii,     "ADD ");
         @(negedge clk);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_valid();
         chk("t1_iw",    32'(o_iw),    32'(14'h0512 + i));
         chk("t1_ts",    32'(o_ts),    32'(ts1[i]));
         chk("t1_ascii", o_ascii,      "ADD ");
         chk("t1_last",  32'(o_last),  (i == 4) ? 32'd1 : 32'd0);
         chk("t1_cnt",   32'(o_count), 32'(5 - i));
         @(negedge clk);
      end
      rd_ready = 1'b0;
      chk("t1_end_valid", 32'(o_valid), 32'd0);
      chk("t1_end_state", 32'(o_state), 32'd0);
      chk("t1_end_count", 32'(o_count), 32'd0);

      // B: 21 IWs, overflow, trigger with no post window
      sel = 1'b1; #1;
      trig_opc = 6'h1C; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      for (int i = 0; i < 21; i++) begin
         iw = (i == 20) ? 14'h1C00 : 14'(i); iw_valid = 1'b1; ts2[i] = cyc;
         @(negedge clk);
      end
      iw_valid = 1'b0;
      chk("t2_state", 32'(o_state), 32'd3);
      chk("t2_count", 32'(o_count), 32'd16);
      chk("t2_ovf",   32'(o_ovf),   32'd1);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      chk("t2_arm_drain_state", 32'(o_state), 32'd3);
      chk("t2_arm_drain_count", 32'(o_count), 32'd16);
      chk("t2_arm_drain_ovf",   32'(o_ovf),   32'd1);
      rd_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         wait_valid();
         chk("t2_iw",    32'(o_iw),   (k == 15) ? 32'h1C00 : 32'(k + 5));
         chk("t2_ts",    32'(o_ts),   32'(ts2[k + 5]));
         chk("t2_ascii", o_ascii,     (k == 15) ? "RET " : "LD  ");
         chk("t2_last",  32'(o_last), (k == 15) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      rd_ready = 1'b0;
      chk("t2_end_state", 32'(o_state), 32'd0);
      chk("t2_end_count", 32'(o_count), 32'd0);

      // A: STALL filtered, then Arm coincident with trigger IW
      sel = 1'b0; #1;
      trig_opc = 6'h05; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      iw = 14'h3FFF; iw_valid = 1'b1;
      @(negedge clk);
      iw_valid = 1'b0;
      chk("t3_stall_count", 32'(o_count), 32'd0);
      chk("t3_stall_state", 32'(o_state), 32'd1);
      iw = 14'h0100; iw_valid = 1'b1;
      @(negedge clk);
      chk("t3_rec_count", 32'(o_count), 32'd1);
      arm = 1'b1; iw = 14'h0512;
      @(negedge clk);
      arm = 1'b0; iw_valid = 1'b0;
      chk("t3_armtrig_state", 32'(o_state), 32'd1);
      chk("t3_armtrig_count", 32'(o_count), 32'd0);

      // B: STALL recorded when unfiltered
      sel = 1'b1; #1;
      trig_opc = 6'h1C; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      iw = 14'h3FFF; iw_valid = 1'b1; ts3[0] = cyc;
      @(negedge clk);
      iw = 14'h1C00; ts3[1] = cyc;
      @(negedge clk);
      iw_valid = 1'b0;
      chk("t4_count", 32'(o_count), 32'd2);
      chk("t4_state", 32'(o_state), 32'd3);
      wait_valid();
      chk("t4_iw0",    32'(o_iw),   32'h3FFF);
      chk("t4_ts0",    32'(o_ts),   32'(ts3[0]));
      chk("t4_ascii0", o_ascii,     "STAL");
      chk("t4_last0",  32'(o_last), 32'd0);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      wait_valid();
      chk("t4_iw1",    32'(o_iw),   32'h1C00);
      chk("t4_ascii1", o_ascii,     "RET ");
      chk("t4_last1",  32'(o_last), 32'd1);

      // Asynchronous reset between edges while B is draining
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(o_valid), 32'd0);
      chk("t5_rst_state", 32'(o_state), 32'd0);
      chk("t5_rst_count", 32'(o_count), 32'd0);
      chk("t5_rst_last",  32'(o_last),  32'd0);
      sel = 1'b0; #1;
      chk("t5_rst_a_state", 32'(o_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
